// File: rtl/uart_bus_pkg.sv
// Types and widths shared by the UART register-bus master and its helpers.
package uart_bus_pkg;

    localparam int ADDR_W = 4;
    localparam int DATA_W = 8;
    localparam int CNT_W  = 4;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        STROBE,
        HOLD
    } busState_t;

    // A phase lasting N cycles counts down from N-1 and moves on when it reaches zero.
    function automatic logic [CNT_W-1:0] phaseLoad(input int unsigned cycles);
        phaseLoad = CNT_W'(cycles - 1);
    endfunction

endpackage

// File: rtl/uart_bus_master_irq_edge_sync.sv
// Two-flop synchronizer for the UART core interrupt, plus a registered rising-edge pulse.
module irq_edge_sync (
    input  logic clk,
    input  logic rst,
    input  logic irqAsync,
    output logic irqEdge
);

    logic [1:0] syncReg;
    logic       syncPrevReg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            syncReg     <= '0;
            syncPrevReg <= 1'b0;
            irqEdge     <= 1'b0;
        end else begin
            syncReg     <= {syncReg[0], irqAsync};
            syncPrevReg <= syncReg[1];
            // Pulse is registered, so it appears one cycle after the synchronized edge.
            irqEdge     <= syncReg[1] & ~syncPrevReg;
        end
    end

endmodule

// File: rtl/uart_bus_master.sv
// Host command to UART core register cycle: setup, strobe, hold, then a completion pulse.
module uart_bus_master
    import uart_bus_pkg::*;
#(
    parameter int unsigned SETUP_CYC  = 2,
    parameter int unsigned STROBE_CYC = 4,
    parameter int unsigned HOLD_CYC   = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_we,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic [ADDR_W-1:0] AddrBus_o,
    output logic              n_ChipSelect_o,
    output logic              n_rd_o,
    output logic              n_we_o,
    output logic [DATA_W-1:0] DataBus_o,
    input  logic [DATA_W-1:0] DataBus_i,
    input  logic              p_IrqSig_i,
    output logic              p_IrqEdge_o
);

    localparam logic [CNT_W-1:0] SETUP_LOAD  = phaseLoad(SETUP_CYC);
    localparam logic [CNT_W-1:0] STROBE_LOAD = phaseLoad(STROBE_CYC);
    localparam logic [CNT_W-1:0] HOLD_LOAD   = phaseLoad(HOLD_CYC);

    busState_t         stateReg;
    logic [CNT_W-1:0]  cntReg;
    logic              weReg;
    logic [DATA_W-1:0] capReg;

    // All bus outputs are registered; the async reset releases the strobes immediately.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stateReg       <= IDLE;
            cntReg         <= '0;
            weReg          <= 1'b0;
            capReg         <= '0;
            cmd_ready      <= 1'b1;
            rsp_valid      <= 1'b0;
            rsp_rdata      <= '0;
            AddrBus_o      <= '0;
            DataBus_o      <= '0;
            n_ChipSelect_o <= 1'b1;
            n_rd_o         <= 1'b1;
            n_we_o         <= 1'b1;
        end else begin
            rsp_valid <= 1'b0;
            case (stateReg)
                IDLE: begin
                    if (cmd_valid) begin
                        weReg          <= cmd_we;
                        AddrBus_o      <= cmd_addr;
                        DataBus_o      <= cmd_we ? cmd_wdata : '0;
                        n_ChipSelect_o <= 1'b0;
                        cmd_ready      <= 1'b0;
                        cntReg         <= SETUP_LOAD;
                        stateReg       <= SETUP;
                    end
                end
                SETUP: begin
                    if (cntReg == '0) begin
                        n_we_o   <= ~weReg;
                        n_rd_o   <= weReg;
                        cntReg   <= STROBE_LOAD;
                        stateReg <= STROBE;
                    end else begin
                        cntReg <= cntReg - 1'b1;
                    end
                end
                STROBE: begin
                    if (cntReg == '0) begin
                        // Read data is captured on the edge that ends the strobe.
                        if (!weReg) begin
                            capReg <= DataBus_i;
                        end
                        n_we_o   <= 1'b1;
                        n_rd_o   <= 1'b1;
                        cntReg   <= HOLD_LOAD;
                        stateReg <= HOLD;
                    end else begin
                        cntReg <= cntReg - 1'b1;
                    end
                end
                HOLD: begin
                    if (cntReg == '0) begin
                        n_ChipSelect_o <= 1'b1;
                        cmd_ready      <= 1'b1;
                        rsp_valid      <= 1'b1;
                        rsp_rdata      <= weReg ? '0 : capReg;
                        stateReg       <= IDLE;
                    end else begin
                        cntReg <= cntReg - 1'b1;
                    end
                end
                default: begin
                    n_ChipSelect_o <= 1'b1;
                    n_rd_o         <= 1'b1;
                    n_we_o         <= 1'b1;
                    cmd_ready      <= 1'b1;
                    stateReg       <= IDLE;
                end
            endcase
        end
    end

    irq_edge_sync uIrqSync (
        .clk      (clk),
        .rst      (rst),
        .irqAsync (p_IrqSig_i),
        .irqEdge  (p_IrqEdge_o)
    );

endmodule

// File: tb/tb_uart_bus_master.sv
// Randomized self-checking bench for uart_bus_master against a cycle-window reference model.
module tb_uart_bus_master;

    localparam int S = 2;
    localparam int T = 4;
    localparam int H = 1;
    localparam int L = S + T + H + 1;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       cmdValid = 1'b0, cmdReady, cmdWe = 1'b0;
    logic [3:0] cmdAddr = '0;
    logic [7:0] cmdWdata = '0;
    logic       rspValid;
    logic [7:0] rspRdata;
    logic [3:0] addrBus;
    logic       nCs, nRd, nWe;
    logic [7:0] dataBusOut;
    logic [7:0] dataBusIn = '0;
    logic       irqSig = 1'b0, irqEdge;

    logic       fValid = 1'b0, fReady, fWe = 1'b0;
    logic [3:0] fAddr = '0;
    logic [7:0] fWdata = '0;
    logic       fRspValid;
    logic [7:0] fRspRdata;
    logic [3:0] fAddrBus;
    logic       fNCs, fNRd, fNWe;
    logic [7:0] fDataOut;
    logic [7:0] fDataIn = '0;
    logic       fIrq = 1'b0, fIrqEdge;

    int vectors = 0;
    int miscompares = 0;

    logic       obsCs    [0:63];
    logic       obsWe    [0:63];
    logic       obsRd    [0:63];
    logic       obsValid [0:63];
    logic       obsReady [0:63];
    logic [3:0] obsAddr  [0:63];
    logic [7:0] obsData  [0:63];
    logic [7:0] obsRdata [0:63];
    logic [7:0] drvData  [0:63];

    always #5 clk = ~clk;

    uart_bus_master dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmdValid), .cmd_ready(cmdReady), .cmd_we(cmdWe),
        .cmd_addr(cmdAddr), .cmd_wdata(cmdWdata),
        .rsp_valid(rspValid), .rsp_rdata(rspRdata),
        .AddrBus_o(addrBus), .n_ChipSelect_o(nCs), .n_rd_o(nRd), .n_we_o(nWe),
        .DataBus_o(dataBusOut), .DataBus_i(dataBusIn),
        .p_IrqSig_i(irqSig), .p_IrqEdge_o(irqEdge)
    );

    uart_bus_master #(.SETUP_CYC(1), .STROBE_CYC(1), .HOLD_CYC(1)) dutFast (
        .clk(clk), .rst(rst),
        .cmd_valid(fValid), .cmd_ready(fReady), .cmd_we(fWe),
        .cmd_addr(fAddr), .cmd_wdata(fWdata),
        .rsp_valid(fRspValid), .rsp_rdata(fRspRdata),
        .AddrBus_o(fAddrBus), .n_ChipSelect_o(fNCs), .n_rd_o(fNRd), .n_we_o(fNWe),
        .DataBus_o(fDataOut), .DataBus_i(fDataIn),
        .p_IrqSig_i(fIrq), .p_IrqEdge_o(fIrqEdge)
    );

    // Reference model: cycle k counts clock edges after the accepting edge.
    function automatic logic expCsN(input int k);
        return !(k >= 1 && k <= S + T + H);
    endfunction

    function automatic logic inStrobe(input int k);
        return (k > S) && (k <= S + T);
    endfunction

    // Issues one command and records the DUT outputs for cycles 1..nCyc (no checking here).
    task automatic runTxn(input logic we, input logic [3:0] addr, input logic [7:0] wdata,
                          input logic forceRd, input logic [7:0] rdVal, input int pokeAt,
                          input int nCyc);
        int guard = 0;
        @(negedge clk);
        while (!cmdReady && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        vectors++;
        if (cmdReady !== 1'b1) begin
            miscompares++;
            $display("FAIL ready_timeout: cmd_ready=%b required 1", cmdReady);
        end
        cmdValid = 1'b1; cmdWe = we; cmdAddr = addr; cmdWdata = wdata;
        for (int k = 1; k <= nCyc; k++) begin
            @(negedge clk);
            if (k == 1 || k == pokeAt + 1) begin
                cmdValid = 1'b0;
            end
            if (k == pokeAt) begin
                cmdValid = 1'b1;
            end
            cmdWe = 1'($urandom); cmdAddr = 4'($urandom); cmdWdata = 8'($urandom);
            obsCs[k] = nCs; obsWe[k] = nWe; obsRd[k] = nRd; obsValid[k] = rspValid;
            obsReady[k] = cmdReady; obsAddr[k] = addrBus; obsData[k] = dataBusOut;
            obsRdata[k] = rspRdata;
            drvData[k] = (forceRd && inStrobe(k)) ? rdVal : 8'($urandom);
            dataBusIn = drvData[k];
        end
        cmdValid = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] got;
        @(negedge clk);
        got = {cmdReady, rspValid, rspRdata, addrBus, dataBusOut, nCs, nRd, nWe, irqEdge, 6'd0};
        vectors++;
        if (got !== {1'b1, 1'b0, 8'h00, 4'h0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 6'd0}) begin
            miscompares++;
            $display("FAIL reset_state: got %h required %h", got,
                     {1'b1, 1'b0, 8'h00, 4'h0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 6'd0});
        end
        vectors++;
        if ({fReady, fNCs, fNRd, fNWe, fRspValid} !== 5'b11110) begin
            miscompares++;
            $display("FAIL reset_fast: got %b required 11110", {fReady, fNCs, fNRd, fNWe, fRspValid});
        end
    endtask

    task automatic test_write();
        int weLow = 0;
        runTxn(1'b1, 4'h3, 8'hA5, 1'b0, 8'h00, 0, L + 1);
        for (int k = 1; k <= L + 1; k++) begin
            vectors++;
            if ({obsCs[k], obsWe[k], obsRd[k], obsValid[k]} !==
                {expCsN(k), !inStrobe(k), 1'b1, 1'(k == L)}) begin
                miscompares++;
                $display("FAIL write_cycle%0d cs/we/rd/valid: got %b required %b", k,
                         {obsCs[k], obsWe[k], obsRd[k], obsValid[k]},
                         {expCsN(k), !inStrobe(k), 1'b1, 1'(k == L)});
            end
            vectors++;
            if (obsAddr[k] !== 4'h3 || obsData[k] !== 8'hA5) begin
                miscompares++;
                $display("FAIL write_cycle%0d addr/data: got %h/%h required 3/a5", k, obsAddr[k], obsData[k]);
            end
            if (!obsWe[k]) weLow++;
        end
        vectors++;
        if (weLow != 4 || obsRdata[L] !== 8'h00) begin
            miscompares++;
            $display("FAIL write_summary: we_low=%0d rdata=%h required 4/00", weLow, obsRdata[L]);
        end
    endtask

    task automatic test_read();
        int rdLow = 0;
        runTxn(1'b0, 4'h5, 8'h77, 1'b1, 8'h3C, 0, L + 1);
        for (int k = 1; k <= L + 1; k++) begin
            vectors++;
            if ({obsCs[k], obsWe[k], obsRd[k], obsValid[k]} !==
                {expCsN(k), 1'b1, !inStrobe(k), 1'(k == L)}) begin
                miscompares++;
                $display("FAIL read_cycle%0d cs/we/rd/valid: got %b required %b", k,
                         {obsCs[k], obsWe[k], obsRd[k], obsValid[k]},
                         {expCsN(k), 1'b1, !inStrobe(k), 1'(k == L)});
            end
            if (!obsRd[k]) rdLow++;
        end
        vectors++;
        if (rdLow != 4 || obsRdata[L] !== 8'h3C || obsRdata[L + 1] !== 8'h3C
            || obsData[2] !== 8'h00 || obsAddr[2] !== 4'h5) begin
            miscompares++;
            $display("FAIL read_summary: rd_low=%0d rdata=%h/%h data=%h addr=%h required 4 3c/3c 00 5",
                     rdLow, obsRdata[L], obsRdata[L + 1], obsData[2], obsAddr[2]);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 16; n++) begin
            logic       we   = 1'($urandom);
            logic [3:0] addr = 4'($urandom);
            logic [7:0] wd   = 8'($urandom);
            logic [7:0] expRd;
            runTxn(we, addr, wd, 1'b0, 8'h00, 0, L + 1);
            expRd = we ? 8'h00 : drvData[S + T];
            for (int k = 1; k <= L; k++) begin
                vectors++;
                if ({obsCs[k], obsWe[k], obsRd[k], obsValid[k], obsReady[k]} !==
                    {expCsN(k), !(we && inStrobe(k)), !(!we && inStrobe(k)), 1'(k == L), 1'(k == L)}
                    || obsAddr[k] !== addr || obsData[k] !== (we ? wd : 8'h00)) begin
                    miscompares++;
                    $display("FAIL random%0d_cycle%0d: ctl=%b addr=%h data=%h required ctl=%b addr=%h data=%h",
                             n, k, {obsCs[k], obsWe[k], obsRd[k], obsValid[k], obsReady[k]},
                             obsAddr[k], obsData[k],
                             {expCsN(k), !(we && inStrobe(k)), !(!we && inStrobe(k)), 1'(k == L), 1'(k == L)},
                             addr, we ? wd : 8'h00);
                end
            end
            vectors++;
            if (obsRdata[L] !== expRd || obsRdata[L + 1] !== expRd) begin
                miscompares++;
                $display("FAIL random%0d_rdata: got %h/%h required %h", n, obsRdata[L], obsRdata[L + 1], expRd);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] a1 = 4'($urandom), a2 = 4'($urandom);
        logic [7:0] d1 = 8'($urandom), d2 = 8'($urandom);
        int csHigh = 0;
        @(negedge clk);
        cmdValid = 1'b1; cmdWe = 1'b1; cmdAddr = a1; cmdWdata = d1;
        for (int k = 1; k <= 2 * L + 1; k++) begin
            @(negedge clk);
            if (k == L) begin
                cmdAddr = a2; cmdWdata = d2;
            end
            if (k == L + 1) cmdValid = 1'b0;
            if (k < 2 * L && nCs) csHigh++;
            vectors++;
            if ({nCs, rspValid} !== {1'(k == L || k >= 2 * L), 1'(k == L || k == 2 * L)}) begin
                miscompares++;
                $display("FAIL b2b_cycle%0d cs/valid: got %b required %b", k, {nCs, rspValid},
                         {1'(k == L || k >= 2 * L), 1'(k == L || k == 2 * L)});
            end
            if (k == 2) begin
                vectors++;
                if (addrBus !== a1 || dataBusOut !== d1) begin
                    miscompares++;
                    $display("FAIL b2b_first: got %h/%h required %h/%h", addrBus, dataBusOut, a1, d1);
                end
            end
            if (k == L + 2) begin
                vectors++;
                if (addrBus !== a2 || dataBusOut !== d2) begin
                    miscompares++;
                    $display("FAIL b2b_second: got %h/%h required %h/%h", addrBus, dataBusOut, a2, d2);
                end
            end
        end
        cmdValid = 1'b0;
        vectors++;
        if (csHigh != 1) begin
            miscompares++;
            $display("FAIL b2b_gap: cs high %0d cycles required 1", csHigh);
        end
    endtask

    task automatic test_busy_ignore();
        int pulses = 0;
        logic [3:0] addr = 4'($urandom);
        logic [7:0] wd = 8'($urandom);
        runTxn(1'b1, addr, wd, 1'b0, 8'h00, S + 2, 2 * L + 2);
        for (int k = 1; k <= 2 * L + 2; k++) begin
            if (obsValid[k]) pulses++;
            vectors++;
            if (obsCs[k] !== expCsN(k) || obsAddr[k] !== addr || obsData[k] !== wd) begin
                miscompares++;
                $display("FAIL busy_cycle%0d: cs=%b addr=%h data=%h required cs=%b addr=%h data=%h",
                         k, obsCs[k], obsAddr[k], obsData[k], expCsN(k), addr, wd);
            end
        end
        vectors++;
        if (pulses != 1) begin
            miscompares++;
            $display("FAIL busy_pulses: got %0d required 1", pulses);
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] expRd;
        @(negedge clk);
        cmdValid = 1'b1; cmdWe = 1'b1; cmdAddr = 4'($urandom); cmdWdata = 8'($urandom);
        for (int k = 1; k <= S + 2; k++) begin
            @(negedge clk);
            cmdValid = 1'b0;
        end
        vectors++;
        if (nWe !== 1'b0) begin
            miscompares++;
            $display("FAIL rstmid_pre: n_we=%b required 0", nWe);
        end
        rst = 1'b0;
        #1;
        vectors++;
        if ({nWe, nCs, nRd, rspValid, cmdReady} !== 5'b11101) begin
            miscompares++;
            $display("FAIL rstmid_async: we/cs/rd/valid/ready=%b required 11101", {nWe, nCs, nRd, rspValid, cmdReady});
        end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        for (int k = 1; k <= L + 2; k++) begin
            @(negedge clk);
            vectors++;
            if (rspValid !== 1'b0 || nCs !== 1'b1) begin
                miscompares++;
                $display("FAIL rstmid_quiet%0d: valid=%b cs=%b required 0/1", k, rspValid, nCs);
            end
        end
        runTxn(1'b0, 4'($urandom), 8'h00, 1'b0, 8'h00, 0, L + 1);
        expRd = drvData[S + T];
        vectors++;
        if (obsValid[L] !== 1'b1 || obsRdata[L] !== expRd) begin
            miscompares++;
            $display("FAIL rstmid_after: valid=%b rdata=%h required 1/%h", obsValid[L], obsRdata[L], expRd);
        end
    endtask

    task automatic test_irq();
        for (int n = 0; n < 3; n++) begin
            int pulses = 0;
            repeat ($urandom_range(2, 5)) @(negedge clk);
            irqSig = 1'b1;
            for (int j = 1; j <= 10; j++) begin
                @(negedge clk);
                if (irqEdge) pulses++;
                vectors++;
                if (irqEdge !== 1'(j == 3)) begin
                    miscompares++;
                    $display("FAIL irq%0d_cycle%0d: got %b required %b", n, j, irqEdge, 1'(j == 3));
                end
            end
            irqSig = 1'b0;
            for (int j = 1; j <= 5; j++) begin
                @(negedge clk);
                if (irqEdge) pulses++;
            end
            vectors++;
            if (pulses != 1) begin
                miscompares++;
                $display("FAIL irq%0d_pulses: got %0d required 1", n, pulses);
            end
        end
    endtask

    task automatic test_fast_latency();
        @(negedge clk);
        vectors++;
        if (fReady !== 1'b1) begin
            miscompares++;
            $display("FAIL fast_ready: got %b required 1", fReady);
        end
        fValid = 1'b1; fWe = 1'b1; fAddr = 4'($urandom); fWdata = 8'($urandom);
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            fValid = 1'b0;
            vectors++;
            if ({fNCs, fNWe, fNRd, fRspValid} !== {1'(!(k >= 1 && k <= 3)), 1'(k != 2), 1'b1, 1'(k == 4)}) begin
                miscompares++;
                $display("FAIL fast_cycle%0d cs/we/rd/valid: got %b required %b", k,
                         {fNCs, fNWe, fNRd, fRspValid},
                         {1'(!(k >= 1 && k <= 3)), 1'(k != 2), 1'b1, 1'(k == 4)});
            end
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        test_reset();
        rst = 1'b1;
        test_write();
        test_read();
        test_random();
        test_back_to_back();
        test_busy_ignore();
        test_reset_mid();
        test_irq();
        test_fast_latency();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
